// File: rtl/uart_tx_buf_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_buf_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int calc_bit_cyc(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte-strobe write port of the UART transmitter with its queue status.
interface uart_tx_buf_if #(
  parameter int FIFO_DEPTH = 16
);
  import uart_tx_buf_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] pi_data;
  logic              pi_flag;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              drop;

  modport master (
    output pi_data, pi_flag,
    input  fifo_full, fifo_cnt, drop
  );

  modport slave (
    input  pi_data, pi_flag,
    output fifo_full, fifo_cnt, drop
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO, first-word-fall-through; push must already be qualified by the caller.
module uart_tx_fifo
  import uart_tx_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              full_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (push && !pop)
      cnt_next = cnt_reg + 1'b1;
    else if (!push && pop)
      cnt_next = cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      cnt_reg  <= cnt_next;
      full_reg <= (cnt_next == CNT_W'(DEPTH));
    end
  end

  assign dout = mem_reg[rd_ptr_reg];
  assign full = full_reg;
  assign cnt  = cnt_reg;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  uart_tx_buf_if.slave pi,
  output logic         tx,
  output logic         tx_busy
);

  localparam int BIT_CYC = calc_bit_cyc(CLK_FREQ, UART_BPS);
  localparam int BW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t            state_reg;
  logic [BW-1:0]     baud_reg;
  logic [2:0]        bit_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              tx_reg;
  logic              drop_reg;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_nonempty;
  logic              baud_end;
  logic              pop;
  logic              push_ok;

  assign fifo_nonempty = (fifo_cnt != '0);
  assign baud_end      = (baud_reg == BW'(BIT_CYC - 1));
  assign pop           = fifo_nonempty &&
                         ((state_reg == IDLE) || (state_reg == STOP && baud_end));
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push_ok       = pi.pi_flag && (!fifo_full || pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk  (sys_clk),
    .srst (sys_rst),
    .push (push_ok),
    .pop  (pop),
    .din  (pi.pi_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .cnt  (fifo_cnt)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      drop_reg  <= 1'b0;
    end else begin
      drop_reg <= pi.pi_flag && !push_ok;
      if (state_reg != IDLE)
        baud_reg <= baud_end ? '0 : baud_reg + 1'b1;

      // tx is loaded with the value of the bit being entered, so it changes on the same edge as the state.
      case (state_reg)
        IDLE: begin
          if (fifo_nonempty) begin
            shift_reg <= fifo_dout;
            state_reg <= START;
            baud_reg  <= '0;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state_reg <= DATA;
            bit_reg   <= '0;
            tx_reg    <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= ^shift_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_reg <= bit_reg + 3'd1;
              tx_reg  <= shift_reg[bit_reg + 3'd1];
            end
          end
        end
        PARITY: begin
          if (baud_end) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (fifo_nonempty) begin
              shift_reg <= fifo_dout;
              state_reg <= START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state_reg != IDLE);
  assign pi.fifo_full = fifo_full;
  assign pi.fifo_cnt  = fifo_cnt;
  assign pi.drop      = drop_reg;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf at BIT_CYC=10 (CLK_FREQ=1000, UART_BPS=100, FIFO_DEPTH=16).
module tb_uart_tx_buf;
  import uart_tx_buf_pkg::*;

  localparam int BIT_CYC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic tx;
  logic tx_busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_buf_if #(.FIFO_DEPTH(16)) bus ();

  uart_tx_buf #(
    .UART_BPS   (100),
    .CLK_FREQ   (1000),
    .FIFO_DEPTH (16)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pi      (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NBITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Called at the negedge that is 'skip' cycles into a frame; checks first and last cycle of every bit.
  task automatic check_frame(input logic [7:0] b, input int skip, input bit push_last,
                             input logic [7:0] push_data);
    for (int c = 0; c < NBITS * BIT_CYC; c++) begin
      if (c >= skip) begin
        if (c % BIT_CYC == 0 || c % BIT_CYC == BIT_CYC - 1)
          chk($sformatf("frame_%02h_c%0d", b, c), 32'(tx), 32'(frame_bit(b, c / BIT_CYC)));
        if (push_last && c == NBITS * BIT_CYC - 1) begin
          bus.pi_flag = 1'b1;
          bus.pi_data = push_data;
        end
        @(negedge sys_clk);
        bus.pi_flag = 1'b0;
      end
    end
  endtask

  task automatic send_single(input logic [7:0] b);
    bus.pi_flag = 1'b1;
    bus.pi_data = b;
    @(negedge sys_clk);
    bus.pi_flag = 1'b0;
    chk("single_cnt_e1", 32'(bus.fifo_cnt), 32'd1);
    chk("single_tx_e1", 32'(tx), 32'd1);
    chk("single_busy_e1", 32'(tx_busy), 32'd0);
    @(negedge sys_clk);
    chk("single_cnt_e2", 32'(bus.fifo_cnt), 32'd0);
    chk("single_busy_e2", 32'(tx_busy), 32'd1);
    check_frame(b, 0, 1'b0, 8'h00);
    chk("single_busy_end", 32'(tx_busy), 32'd0);
    chk("single_tx_end", 32'(tx), 32'd1);
  endtask

  // Pushes n bytes on consecutive edges starting from an idle, empty transmitter.
  task automatic burst(input int n, input logic [7:0] base);
    int exp_cnt;
    for (int i = 0; i < n; i++) begin
      bus.pi_flag = 1'b1;
      bus.pi_data = base + 8'(i);
      @(negedge sys_clk);
      exp_cnt = (i == 0) ? 1 : ((i > 16) ? 16 : i);
      chk($sformatf("burst_cnt_%0d", i), 32'(bus.fifo_cnt), 32'(exp_cnt));
      chk($sformatf("burst_full_%0d", i), 32'(bus.fifo_full), 32'(exp_cnt == 16));
      chk($sformatf("burst_drop_%0d", i), 32'(bus.drop), 32'(i >= 17));
      if (i == 1)
        chk("burst_start_tx", 32'(tx), 32'd0);
    end
    bus.pi_flag = 1'b0;
  endtask

  initial begin
    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    sys_rst     = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_cnt", 32'(bus.fifo_cnt), 32'd0);
    chk("rst_drop", 32'(bus.drop), 32'd0);
    sys_rst = 1'b0;

    // Idle line
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      chk($sformatf("idle_tx_%0d", i), 32'(tx), 32'd1);
      chk($sformatf("idle_busy_%0d", i), 32'(tx_busy), 32'd0);
      chk($sformatf("idle_cnt_%0d", i), 32'(bus.fifo_cnt), 32'd0);
    end
    $display("step idle: done");

    send_single(8'hA5);
    $display("step single 0xA5: done");
    send_single(8'h07);
    $display("step single 0x07: done");

    // Three back-to-back frames; bench is 1 cycle into the first frame after the burst
    burst(3, 8'h01);
    check_frame(8'h01, 1, 1'b0, 8'h00);
    check_frame(8'h02, 0, 1'b0, 8'h00);
    check_frame(8'h03, 0, 1'b0, 8'h00);
    chk("burst3_busy_end", 32'(tx_busy), 32'd0);
    $display("step burst of 3: done");

    // Overflow: 20 pushes, 3 dropped; one more byte pushed as the first STOP ends
    burst(20, 8'h10);
    check_frame(8'h10, 18, 1'b1, 8'h5C);
    chk("ovf_cnt_stop_push", 32'(bus.fifo_cnt), 32'd16);
    chk("ovf_full_stop_push", 32'(bus.fifo_full), 32'd1);
    chk("ovf_drop_stop_push", 32'(bus.drop), 32'd0);
    for (int i = 1; i <= 16; i++)
      check_frame(8'h10 + 8'(i), 0, 1'b0, 8'h00);
    check_frame(8'h5C, 0, 1'b0, 8'h00);
    chk("ovf_busy_end", 32'(tx_busy), 32'd0);
    chk("ovf_cnt_end", 32'(bus.fifo_cnt), 32'd0);
    $display("step overflow of 20: done");

    // Reset in the middle of the 0xFF data bits with 4 bytes queued
    burst(5, 8'hFF);
    repeat (32) @(negedge sys_clk);
    chk("rst_mid_busy_before", 32'(tx_busy), 32'd1);
    chk("rst_mid_cnt_before", 32'(bus.fifo_cnt), 32'd4);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    chk("rst_mid_cnt", 32'(bus.fifo_cnt), 32'd0);
    chk("rst_mid_full", 32'(bus.fifo_full), 32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge sys_clk);
      chk($sformatf("post_rst_tx_%0d", i), 32'(tx), 32'd1);
      chk($sformatf("post_rst_busy_%0d", i), 32'(tx_busy), 32'd0);
    end
    $display("step reset mid-frame: done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
